// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
//   Shared pipeline definitions: exception codes carried with each entry,
//   the default Tnew field width, the all-zero NOP payload and the
//   occupancy encoding used by the stage register.
package pipe_stage_reg_pkg;

    // Exception codes (MIPS Cause.ExcCode subset used by the pipeline)
    localparam logic [4:0] EXC_ADEL = 5'd4;   // address error on load/fetch
    localparam logic [4:0] EXC_ADES = 5'd5;   // address error on store
    localparam logic [4:0] EXC_OV   = 5'd12;  // arithmetic overflow

    localparam int unsigned TNEW_W_DEF = 2;

    // Wide enough for any supported payload; sliced to WIDTH by users.
    localparam int unsigned NOP_MAX_W = 1024;
    localparam logic [NOP_MAX_W-1:0] NOP_PAYLOAD = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
//   Groups the upstream (in_*), downstream (out_*), flush and occupancy
//   signals of one pipeline stage register.
//   master : the surrounding pipeline (drives in_*, flush, out_ready)
//   slave  : the stage register itself
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned TNEW_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [TNEW_W-1:0] in_tnew;
    logic              in_exc;
    logic              in_slot;
    logic [4:0]        in_exccode;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [TNEW_W-1:0] out_tnew;
    logic              out_exc;
    logic              out_slot;
    logic [4:0]        out_exccode;
    logic [1:0]        count;

    modport master (
        output in_valid, in_data, in_tnew, in_exc, in_slot, in_exccode,
        output flush, out_ready,
        input  in_ready, out_valid, out_data, out_tnew, out_exc, out_slot,
        input  out_exccode, count
    );

    modport slave (
        input  in_valid, in_data, in_tnew, in_exc, in_slot, in_exccode,
        input  flush, out_ready,
        output in_ready, out_valid, out_data, out_tnew, out_exc, out_slot,
        output out_exccode, count
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg
//   One pipeline entry: {valid, data, tnew, exc, slot, exccode}.
//   Ports: clk, reset (async active-low), i_load (capture i_* and set
//   valid), i_clear (empty and zero all fields; wins over i_load),
//   i_data/i_tnew/i_exc/i_slot/i_exccode, o_* registered fields.
module pipe_entry_reg #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [WIDTH-1:0]  i_data,
    input  logic [TNEW_W-1:0] i_tnew,
    input  logic              i_exc,
    input  logic              i_slot,
    input  logic [4:0]        i_exccode,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_data,
    output logic [TNEW_W-1:0] o_tnew,
    output logic              o_exc,
    output logic              o_slot,
    output logic [4:0]        o_exccode
);

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [TNEW_W-1:0] r_tnew;
    logic              r_exc;
    logic              r_slot;
    logic [4:0]        r_exccode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_tnew    <= '0;
            r_exc     <= 1'b0;
            r_slot    <= 1'b0;
            r_exccode <= '0;
        end else if (i_clear) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_tnew    <= '0;
            r_exc     <= 1'b0;
            r_slot    <= 1'b0;
            r_exccode <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_data    <= i_data;
            r_tnew    <= i_tnew;
            r_exc     <= i_exc;
            r_slot    <= i_slot;
            r_exccode <= i_exccode;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_tnew    = r_tnew;
    assign o_exc     = r_exc;
    assign o_slot    = r_slot;
    assign o_exccode = r_exccode;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Two-entry (head + skid) pipeline stage register with registered
//   in_ready, flush, Tnew decrement on capture and NOP output when empty.
//   Ports: clk, reset (async active-low), bus (pipe_stage_reg_if.slave:
//   in_valid/in_ready/in_data/in_tnew/in_exc/in_slot/in_exccode, flush,
//   out_valid/out_ready/out_data/out_tnew/out_exc/out_slot/out_exccode,
//   count).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned TNEW_W   = TNEW_W_DEF,
    parameter int unsigned TNEW_DEC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_stage_reg_if.slave       bus
);

    localparam logic [TNEW_W-1:0] DEC = TNEW_W'(TNEW_DEC);

    occ_e              r_occ, w_occ_nxt;
    logic              r_in_ready, w_in_ready_nxt;

    logic              w_accept, w_release;
    logic [TNEW_W-1:0] w_tnew_cap;

    logic              w_head_valid, w_head_exc, w_head_slot;
    logic [WIDTH-1:0]  w_head_data;
    logic [TNEW_W-1:0] w_head_tnew;
    logic [4:0]        w_head_exccode;

    logic              w_skid_valid, w_skid_exc, w_skid_slot;
    logic [WIDTH-1:0]  w_skid_data;
    logic [TNEW_W-1:0] w_skid_tnew;
    logic [4:0]        w_skid_exccode;

    logic              w_head_from_skid, w_head_from_in;
    logic              w_head_load, w_head_clear;
    logic              w_skid_load, w_skid_clear;
    logic [WIDTH-1:0]  w_hd_data;
    logic [TNEW_W-1:0] w_hd_tnew;
    logic              w_hd_exc, w_hd_slot;
    logic [4:0]        w_hd_exccode;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_release  = w_head_valid & bus.out_ready;
    assign w_tnew_cap = (bus.in_tnew > DEC) ? (bus.in_tnew - DEC) : '0;

    // Entry steering. in_ready is "skid empty", so an accept never
    // coincides with a full skid; the skid therefore only refills when the
    // head is held.
    always_comb begin
        w_head_from_skid = w_release & w_skid_valid;
        w_head_from_in   = w_accept & (~w_head_valid | w_release);
        w_head_load      = ~bus.flush & (w_head_from_skid | w_head_from_in);
        w_head_clear     = bus.flush | (w_release & ~w_head_from_skid & ~w_head_from_in);
        w_skid_load      = ~bus.flush & w_accept & w_head_valid & ~w_release;
        w_skid_clear     = bus.flush | w_head_from_skid;

        w_hd_data    = bus.in_data;
        w_hd_tnew    = w_tnew_cap;
        w_hd_exc     = bus.in_exc;
        w_hd_slot    = bus.in_slot;
        w_hd_exccode = bus.in_exccode;
        if (w_head_from_skid) begin
            w_hd_data    = w_skid_data;
            w_hd_tnew    = w_skid_tnew;
            w_hd_exc     = w_skid_exc;
            w_hd_slot    = w_skid_slot;
            w_hd_exccode = w_skid_exccode;
        end
    end

    pipe_entry_reg #(.WIDTH(WIDTH), .TNEW_W(TNEW_W)) u_head (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_head_load),
        .i_clear   (w_head_clear),
        .i_data    (w_hd_data),
        .i_tnew    (w_hd_tnew),
        .i_exc     (w_hd_exc),
        .i_slot    (w_hd_slot),
        .i_exccode (w_hd_exccode),
        .o_valid   (w_head_valid),
        .o_data    (w_head_data),
        .o_tnew    (w_head_tnew),
        .o_exc     (w_head_exc),
        .o_slot    (w_head_slot),
        .o_exccode (w_head_exccode)
    );

    pipe_entry_reg #(.WIDTH(WIDTH), .TNEW_W(TNEW_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_skid_load),
        .i_clear   (w_skid_clear),
        .i_data    (bus.in_data),
        .i_tnew    (w_tnew_cap),
        .i_exc     (bus.in_exc),
        .i_slot    (bus.in_slot),
        .i_exccode (bus.in_exccode),
        .o_valid   (w_skid_valid),
        .o_data    (w_skid_data),
        .o_tnew    (w_skid_tnew),
        .o_exc     (w_skid_exc),
        .o_slot    (w_skid_slot),
        .o_exccode (w_skid_exccode)
    );

    // Occupancy state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ      <= OCC_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_occ      <= w_occ_nxt;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    // Occupancy next state; flush dominates accept and release
    always_comb begin
        w_occ_nxt = r_occ;
        if (bus.flush) begin
            w_occ_nxt = OCC_EMPTY;
        end else begin
            unique case (r_occ)
                OCC_EMPTY: if (w_accept) w_occ_nxt = OCC_ONE;
                OCC_ONE: begin
                    if (w_accept && !w_release)      w_occ_nxt = OCC_FULL;
                    else if (!w_accept && w_release) w_occ_nxt = OCC_EMPTY;
                end
                OCC_FULL:  if (w_release) w_occ_nxt = OCC_ONE;
                default:   w_occ_nxt = OCC_EMPTY;
            endcase
        end
        // in_ready mirrors the skid valid bit it will have after this edge
        w_in_ready_nxt = ~(w_skid_load | (w_skid_valid & ~w_skid_clear));
    end

    // Outputs: an empty stage presents an all-zero NOP entry
    always_comb begin
        bus.in_ready    = r_in_ready;
        bus.count       = r_occ;
        bus.out_valid   = w_head_valid;
        bus.out_data    = NOP_PAYLOAD[WIDTH-1:0];
        bus.out_tnew    = '0;
        bus.out_exc     = 1'b0;
        bus.out_slot    = 1'b0;
        bus.out_exccode = '0;
        if (w_head_valid) begin
            bus.out_data    = w_head_data;
            bus.out_tnew    = w_head_tnew;
            bus.out_exc     = w_head_exc;
            bus.out_slot    = w_head_slot;
            bus.out_exccode = w_head_exccode;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int unsigned W  = 128;
    localparam int unsigned TW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [TW-1:0] in_tnew = '0;
    logic          in_exc = 1'b0;
    logic          in_slot = 1'b0;
    logic [4:0]    in_exccode = '0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(W), .TNEW_W(TW)) ifa ();
    pipe_stage_reg_if #(.WIDTH(W), .TNEW_W(TW)) ifb ();

    assign ifa.in_valid   = in_valid;
    assign ifa.in_data    = in_data;
    assign ifa.in_tnew    = in_tnew;
    assign ifa.in_exc     = in_exc;
    assign ifa.in_slot    = in_slot;
    assign ifa.in_exccode = in_exccode;
    assign ifa.flush      = flush;
    assign ifa.out_ready  = out_ready;
    assign ifb.in_valid   = in_valid;
    assign ifb.in_data    = in_data;
    assign ifb.in_tnew    = in_tnew;
    assign ifb.in_exc     = in_exc;
    assign ifb.in_slot    = in_slot;
    assign ifb.in_exccode = in_exccode;
    assign ifb.flush      = flush;
    assign ifb.out_ready  = out_ready;

    pipe_stage_reg #(.WIDTH(W), .TNEW_W(TW), .TNEW_DEC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    pipe_stage_reg #(.WIDTH(W), .TNEW_W(TW), .TNEW_DEC(0)) dut_d2e (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"},   W'(ifa.out_valid),   '0);
        chk({tag, ".count"},   W'(ifa.count),       '0);
        chk({tag, ".inrdy"},   W'(ifa.in_ready),    W'(1));
        chk({tag, ".data"},    ifa.out_data,        '0);
        chk({tag, ".tnew"},    W'(ifa.out_tnew),    '0);
        chk({tag, ".exc"},     W'(ifa.out_exc),     '0);
        chk({tag, ".slot"},    W'(ifa.out_slot),    '0);
        chk({tag, ".exccode"}, W'(ifa.out_exccode), '0);
    endtask

    initial begin
        // ---- reset state
        cyc();
        cyc();
        chk_empty("rst");
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk_empty("rst_rel");

        // ---- streaming 1..8 with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            cyc();
            chk("stream.valid", W'(ifa.out_valid), W'(1));
            chk("stream.data",  ifa.out_data,      W'(i));
            chk("stream.count", W'(ifa.count),     W'(1));
            chk("stream.inrdy", W'(ifa.in_ready),  W'(1));
        end
        in_valid = 1'b0;
        cyc();
        chk_empty("stream_drain");

        // ---- back-pressure: A, B in flight, C offered while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        cyc();
        chk("bp.A.data",  ifa.out_data,     W'('hA));
        chk("bp.A.count", W'(ifa.count),    W'(1));
        chk("bp.A.inrdy", W'(ifa.in_ready), W'(1));
        in_data = W'('hB);
        cyc();
        chk("bp.B.data",  ifa.out_data,     W'('hA));
        chk("bp.B.count", W'(ifa.count),    W'(2));
        chk("bp.B.inrdy", W'(ifa.in_ready), W'(0));
        in_data = W'('hC);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp.hold.data",  ifa.out_data,     W'('hA));
            chk("bp.hold.count", W'(ifa.count),    W'(2));
            chk("bp.hold.inrdy", W'(ifa.in_ready), W'(0));
        end
        out_ready = 1'b1;
        cyc();
        chk("bp.out1.data",  ifa.out_data,     W'('hB));
        chk("bp.out1.count", W'(ifa.count),    W'(1));
        chk("bp.out1.inrdy", W'(ifa.in_ready), W'(1));
        cyc();
        chk("bp.out2.data",  ifa.out_data,     W'('hC));
        chk("bp.out2.count", W'(ifa.count),    W'(1));
        in_valid = 1'b0;
        cyc();
        chk_empty("bp_drain");

        // ---- Tnew decrement on capture
        in_valid = 1'b1;
        in_data  = W'('h21);
        in_tnew  = 2'd2;
        cyc();
        chk("tnew2.dec1", W'(ifa.out_tnew), W'(1));
        chk("tnew2.dec0", W'(ifb.out_tnew), W'(2));
        in_tnew = 2'd1;
        cyc();
        chk("tnew1.dec1", W'(ifa.out_tnew), W'(0));
        chk("tnew1.dec0", W'(ifb.out_tnew), W'(1));
        in_tnew = 2'd0;
        cyc();
        chk("tnew0.dec1", W'(ifa.out_tnew), W'(0));
        chk("tnew0.dec0", W'(ifb.out_tnew), W'(0));
        // held Tnew does not age while stalled
        out_ready = 1'b0;
        in_tnew   = 2'd3;
        cyc();
        in_valid = 1'b0;
        in_tnew  = 2'd0;
        in_data  = W'('h22);
        cyc();
        chk("tnew3.dec1", W'(ifa.out_tnew), W'(0));
        chk("tnew.count", W'(ifa.count),    W'(2));
        out_ready = 1'b1;
        cyc();
        chk("tnew3.skid.dec1", W'(ifa.out_tnew), W'(2));
        chk("tnew3.skid.dec0", W'(ifb.out_tnew), W'(3));
        cyc();
        chk("tnew3.stable",    W'(ifa.count),    W'(0));
        chk_empty("tnew_drain");

        // ---- flush with count=2, in_valid and out_ready high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h31);
        cyc();
        in_data = W'('h32);
        cyc();
        chk("fl.pre.count", W'(ifa.count), W'(2));
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = W'('h33);
        cyc();
        chk_empty("flush2");
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fl.after.valid", W'(ifa.out_valid), '0);
        end
        // flush with one entry and a concurrent accept
        in_valid = 1'b1;
        in_data  = W'('h41);
        cyc();
        in_data = W'('h42);
        flush   = 1'b1;
        cyc();
        chk_empty("flush1");
        flush    = 1'b0;
        in_valid = 1'b0;
        cyc();
        chk("fl1.after.valid", W'(ifa.out_valid), '0);

        // ---- exception fields travel with their entry
        in_valid   = 1'b1;
        in_data    = W'('h55);
        in_exc     = 1'b1;
        in_exccode = EXC_ADEL;
        in_slot    = 1'b1;
        cyc();
        chk("exc1.data", ifa.out_data,        W'('h55));
        chk("exc1.exc",  W'(ifa.out_exc),     W'(1));
        chk("exc1.code", W'(ifa.out_exccode), W'(4));
        chk("exc1.slot", W'(ifa.out_slot),    W'(1));
        in_data    = W'('h56);
        in_exccode = EXC_OV;
        in_slot    = 1'b0;
        cyc();
        chk("exc2.code", W'(ifa.out_exccode), W'(12));
        chk("exc2.slot", W'(ifa.out_slot),    W'(0));
        in_data    = W'('h57);
        in_exccode = EXC_ADES;
        cyc();
        chk("exc3.code", W'(ifa.out_exccode), W'(5));
        in_valid   = 1'b0;
        in_exc     = 1'b0;
        in_exccode = '0;
        cyc();
        chk_empty("exc_drain");

        // ---- asynchronous reset mid-stream with two entries held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h61);
        in_exc    = 1'b1;
        cyc();
        in_data = W'('h62);
        cyc();
        chk("mrst.pre.count", W'(ifa.count), W'(2));
        in_valid = 1'b0;
        in_exc   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_empty("mrst_async");
        repeat (3) @(posedge clk);
        #1;
        chk_empty("mrst_hold");
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk_empty("mrst_rel");
        in_valid = 1'b1;
        in_data  = W'('h70);
        cyc();
        chk("mrst.new.data",  ifa.out_data,  W'('h70));
        chk("mrst.new.count", W'(ifa.count), W'(1));
        in_valid = 1'b0;
        cyc();
        chk_empty("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
